systolic_seq_ctrl: RTL and testbench

Sequencer for the N×N weight-stationary systolic array built from processing elements (PEs). On a start pulse it does four things in order: buffers one weight tile from a ready/valid source, then shifts the tile down the array columns with the PE load line. It then streams a programmable number of activation vectors into the array's left edge with per-row skew. Finally it tracks when each column's result emerges at the bottom edge. It sits between the tile/activation buffers and the array, and it is the only driver of the array's load, weight and value inputs.

---
 rtl/systolic_seq_ctrl.sv | 119 +++++++++++
 tb/tb_systolic_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences weight fetch/load, skewed activation streaming and result tracking
// for an N x N weight-stationary systolic array.
module systolic_seq_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              num_vecs,
    output logic                    busy,
    output logic                    done,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [N*DATA_WIDTH-1:0] w_data,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [N*DATA_WIDTH-1:0] a_data,
    output logic                    pe_load,
    output logic [N*DATA_WIDTH-1:0] pe_weight,
    output logic [N*DATA_WIDTH-1:0] pe_val,
    output logic [N-1:0]            col_valid
);
    localparam int W = N * DATA_WIDTH;
    localparam int IW = $clog2(N);
    localparam logic [7:0] ROWS = 8'(N - 1);
    localparam logic [7:0] LAST = 8'(2 * N - 2);

    typedef enum logic [2:0] {IDLE, WFETCH, WLOAD, STREAM, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic [7:0] cnt, cnt_n, m_q;
    logic [W-1:0] tile [N];
    logic [W-1:0] weight_n;
    logic [IW-1:0] widx;
    logic [2*N-1:0] tk;
    logic w_beat, a_beat;

    assign w_beat = w_valid & w_ready;
    assign a_beat = a_valid & a_ready;
    assign col_valid = tk[2*N-1:N];

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (start) begin
                state_n = WFETCH;
                cnt_n = '0;
            end
            WFETCH: if (w_beat) begin
                state_n = (cnt == ROWS) ? WLOAD : WFETCH;
                cnt_n = (cnt == ROWS) ? '0 : cnt + 8'd1;
            end
            WLOAD: begin
                state_n = (cnt != LAST) ? WLOAD : (m_q != 8'd0) ? STREAM : DRAIN;
                cnt_n = (cnt == LAST) ? '0 : cnt + 8'd1;
            end
            STREAM: if (a_beat) begin
                state_n = (cnt + 8'd1 == m_q) ? DRAIN : STREAM;
                cnt_n = (cnt + 8'd1 == m_q) ? '0 : cnt + 8'd1;
            end
            DRAIN: begin
                state_n = (cnt == LAST) ? DONE : DRAIN;
                cnt_n = (cnt == LAST) ? '0 : cnt + 8'd1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Rows go out bottom-first, two cycles apart; the first one bypasses the
    // buffer because it is still being written on the entry edge.
    always_comb begin
        widx = IW'(N - 1) - cnt_n[IW:1];
        weight_n = (state_n != WLOAD || cnt_n[0]) ? '0 : (state == WFETCH) ? w_data : tile[widx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            m_q <= '0;
            for (int r = 0; r < N; r++) tile[r] <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            w_ready <= 1'b0;
            a_ready <= 1'b0;
            pe_load <= 1'b0;
            pe_weight <= '0;
            tk <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (state == IDLE && start) m_q <= num_vecs;
            if (state == WFETCH && w_beat) tile[cnt[IW-1:0]] <= w_data;
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            w_ready <= state_n == WFETCH;
            a_ready <= state_n == STREAM;
            pe_load <= state_n == WLOAD;
            pe_weight <= weight_n;
            tk <= {tk[2*N-2:0], a_beat};
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr [k+1];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int d = 0; d <= k; d++) sr[d] <= '0;
            end else begin
                sr[0] <= a_beat ? a_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int d = 1; d <= k; d++) sr[d] <= sr[d-1];
            end
        end
        assign pe_val[k*DATA_WIDTH +: DATA_WIDTH] = sr[k];
    end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed operations with random data/stalls checked against an
// event-timed reference model and a golden array/matmul model.
module tb_systolic_seq_ctrl;
    localparam int DW = 4;
    localparam int N = 4;
    localparam int W = N * DW;

    logic clk = 1'b0;
    logic reset, start, w_valid, a_valid;
    logic [7:0] num_vecs;
    logic [W-1:0] w_data, a_data;
    logic busy, done, w_ready, a_ready, pe_load;
    logic [W-1:0] pe_weight, pe_val;
    logic [N-1:0] col_valid;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
        .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .pe_load(pe_load),
        .pe_weight(pe_weight), .pe_val(pe_val), .col_valid(col_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v, input int k);
        logic signed [DW-1:0] x;
        x = v[k*DW +: DW];
        return int'(x);
    endfunction

    task automatic chk_zero();
        chk("z_busy", 64'(busy), 64'(0));
        chk("z_done", 64'(done), 64'(0));
        chk("z_w_ready", 64'(w_ready), 64'(0));
        chk("z_a_ready", 64'(a_ready), 64'(0));
        chk("z_pe_load", 64'(pe_load), 64'(0));
        chk("z_pe_weight", 64'(pe_weight), 64'(0));
        chk("z_pe_val", 64'(pe_val), 64'(0));
        chk("z_col_valid", 64'(col_valid), 64'(0));
    endtask

    // stall: 0 none, 1 alternate cycles, 2 random
    task automatic run_op(input int m, input int wgap, input int stall, input bit rst2, input bit ident);
        logic [W-1:0] rows [N];
        logic [W-1:0] wobs [N];
        logic [W-1:0] acc [int];
        logic [W-1:0] hist [int];
        logic [W-1:0] wq [$];
        logic [W-1:0] ev, tmp, ewt;
        logic [N-1:0] ec;
        int pulses [N];
        int beats, accepted, lb, dn, od, sc, le, c, se, so;
        bit ew, ea, el, eb, fin;
        beats = 0; accepted = 0; lb = -1; dn = -1; od = -1; sc = 0; fin = 1'b0;
        for (int k = 0; k < N; k++) begin
            rows[k] = ident ? (W'(1) << (k * DW)) : W'($urandom);
            pulses[k] = 0;
            wobs[k] = '0;
        end
        for (int t = 0; t < 1000 && !fin; t++) begin
            @(negedge clk);
            le = lb + 2 * N - 1;
            ew = t > 0 && beats < N;
            el = lb >= 0 && t > lb && t <= le;
            ea = lb >= 0 && m > 0 && t > le && accepted < m;
            if (m == 0 && lb >= 0) dn = le + 2 * N;
            eb = t > 0 && (dn < 0 || t <= dn);
            c = t - lb - 1;
            ewt = '0;
            if (el && c % 2 == 0) ewt = rows[N-1-c/2];
            ev = '0;
            ec = '0;
            for (int k = 0; k < N; k++) begin
                if (acc.exists(t - k - 1)) begin
                    tmp = acc[t-k-1];
                    ev[k*DW +: DW] = tmp[k*DW +: DW];
                end
                if (acc.exists(t - 1 - N - k)) ec[k] = 1'b1;
            end
            chk("busy", 64'(busy), 64'(eb));
            chk("done", 64'(done), 64'(t == dn));
            chk("w_ready", 64'(w_ready), 64'(ew));
            chk("a_ready", 64'(a_ready), 64'(ea));
            chk("pe_load", 64'(pe_load), 64'(el));
            chk("pe_weight", 64'(pe_weight), 64'(ewt));
            chk("pe_val", 64'(pe_val), 64'(ev));
            chk("col_valid", 64'(col_valid), 64'(ec));
            if (done) od = t;
            hist[t] = pe_val;
            if (pe_load) wq.push_back(pe_weight);
            if (lb >= 0 && t == le + 1) begin
                chk("load_len", 64'(wq.size()), 64'(2 * N - 1));
                for (int r = 0; r < N; r++) begin
                    wobs[r] = wq[2*N-2-2*r];
                    chk("array_w", 64'(wobs[r]), 64'(rows[r]));
                end
            end
            for (int j = 0; j < N; j++) begin
                if (col_valid[j]) begin
                    pulses[j]++;
                    if (acc.exists(t - 1 - N - j)) begin
                        tmp = acc[t-1-N-j];
                        se = 0;
                        so = 0;
                        for (int k = 0; k < N; k++) begin
                            se += sx(tmp, k) * sx(rows[k], j);
                            so += sx(hist[t-N-j+k], k) * sx(wobs[k], j);
                        end
                        chk("matmul", 64'(so), 64'(se));
                    end
                end
            end
            if (dn >= 0 && t > dn) begin
                fin = 1'b1;
                start = 1'b0;
                w_valid = 1'b0;
                a_valid = 1'b0;
            end else begin
                start = (t == 0) || (eb && $urandom_range(1) == 1);
                num_vecs = (t == 0) ? 8'(m) : 8'($urandom);
                w_valid = t > 0 && !(wgap > 0 && t >= 2 && t < 2 + wgap);
                w_data = (beats < N) ? rows[beats] : W'($urandom);
                a_valid = (stall == 0) ? 1'b1 : (stall == 1) ? (t % 2 == 1) : ($urandom_range(2) != 0);
                a_data = ident ? {N{DW'(1)}} : W'($urandom);
                if (w_valid && ew) begin
                    beats++;
                    if (beats == N) lb = t;
                end
                if (ea) sc++;
                if (rst2 && ea && sc == 2) begin
                    reset = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    chk_zero();
                    reset = 1'b0;
                    return;
                end
                if (a_valid && ea) begin
                    acc[t] = a_data;
                    accepted++;
                    if (accepted == m) dn = t + 2 * N;
                end
            end
        end
        if (!fin) chk("timeout", 64'(0), 64'(1));
        else begin
            for (int j = 0; j < N; j++) chk("pulses", 64'(pulses[j]), 64'(m));
            if (stall == 0 && wgap == 0) chk("latency", 64'(od + 1), 64'(5 * N + m));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_vecs = '0;
        w_valid = 1'b0;
        w_data = '0;
        a_valid = 1'b0;
        a_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero();
        reset = 1'b0;
        run_op(1, 0, 0, 1'b0, 1'b1);
        run_op(3, 0, 1, 1'b0, 1'b0);
        run_op(5, 5, 0, 1'b0, 1'b0);
        run_op(0, 0, 0, 1'b0, 1'b0);
        run_op(6, 0, 2, 1'b1, 1'b0);
        run_op(8, 2, 2, 1'b0, 1'b0);
        run_op(4, 0, 0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
